// File: rtl/hack_pkg.sv
// Shared encodings for the Hack CPU control path: sequencer states, instruction
// field positions and jump condition codes.
package hack_pkg;

    typedef enum logic [2:0] {
        ST_RST_PC = 3'd0,
        ST_IDLE   = 3'd1,
        ST_FETCH  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam int unsigned IR_W    = 16;
    localparam int unsigned IS_C    = 15;
    localparam int unsigned A_BIT   = 12;
    localparam int unsigned CTRL_HI = 11;
    localparam int unsigned CTRL_LO = 6;
    localparam int unsigned DEST_A  = 5;
    localparam int unsigned DEST_D  = 4;
    localparam int unsigned DEST_M  = 3;
    localparam int unsigned JMP_HI  = 2;
    localparam int unsigned JMP_LO  = 0;
    localparam int unsigned JMP_W   = 3;

    localparam logic [JMP_W-1:0] J_NULL = 3'b000;
    localparam logic [JMP_W-1:0] JGT    = 3'b001;
    localparam logic [JMP_W-1:0] JEQ    = 3'b010;
    localparam logic [JMP_W-1:0] JGE    = 3'b011;
    localparam logic [JMP_W-1:0] JLT    = 3'b100;
    localparam logic [JMP_W-1:0] JNE    = 3'b101;
    localparam logic [JMP_W-1:0] JLE    = 3'b110;
    localparam logic [JMP_W-1:0] JMP    = 3'b111;

endpackage

// File: rtl/hack_jump_eval.sv
// Jump condition evaluator: maps a Hack jump code and the ALU flags to branch-taken.
module hack_jump_eval
    import hack_pkg::*;
(
    input  logic [JMP_W-1:0] j,
    input  logic             zr,
    input  logic             ng,
    output logic             taken
);

    logic lt, eq, gt;

    always_comb begin
        lt    = ng;
        eq    = zr;
        gt    = !ng && !zr;
        taken = 1'b0;
        unique case (j)
            J_NULL:  taken = 1'b0;
            JGT:     taken = gt;
            JEQ:     taken = eq;
            JGE:     taken = eq || gt;
            JLT:     taken = lt;
            JNE:     taken = lt || gt;
            JLE:     taken = lt || eq;
            JMP:     taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/hack_sequencer.sv
// Multi-cycle Hack CPU control unit: ROM fetch handshake, A/C decode, M-write stall,
// run/single-step control, halt-loop detection and fetch-timeout fault.
module hack_sequencer
    import hack_pkg::*;
#(
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        rom_valid,
    output logic        rom_req,
    input  logic [15:0] pc,
    input  logic [15:0] a_val,
    input  logic        alu_zr,
    input  logic        alu_ng,
    input  logic        mem_ready,
    input  logic        run,
    input  logic        step,
    output logic        pc_reset,
    output logic        pc_load,
    output logic        pc_inc,
    output logic        a_load,
    output logic        a_sel_instr,
    output logic        d_load,
    output logic        m_write,
    output logic        am_sel,
    output logic [5:0]  alu_ctrl,
    output logic [15:0] ir,
    output logic [15:0] instr_count,
    output logic        halted,
    output logic        fault
);

    localparam int unsigned     TMO_W    = 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_q;
    logic             taken;
    logic             commit, halt_set, ir_capture, tmo_inc, fault_set;

    hack_jump_eval u_jump (
        .j     (ir[JMP_HI:JMP_LO]),
        .zr    (alu_zr),
        .ng    (alu_ng),
        .taken (taken)
    );

    // Next state and combinational strobes
    always_comb begin
        state_d     = state_q;
        rom_req     = 1'b0;
        pc_reset    = 1'b0;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        a_load      = 1'b0;
        a_sel_instr = 1'b0;
        d_load      = 1'b0;
        m_write     = 1'b0;
        am_sel      = 1'b0;
        alu_ctrl    = 6'd0;
        commit      = 1'b0;
        halt_set    = 1'b0;
        ir_capture  = 1'b0;
        tmo_inc     = 1'b0;
        fault_set   = 1'b0;

        if (reset) begin
            pc_reset = 1'b1;
            state_d  = ST_RST_PC;
        end else begin
            unique case (state_q)
                ST_RST_PC: begin
                    pc_reset = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_IDLE: begin
                    if (run || step) state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    rom_req = 1'b1;
                    if (rom_valid) begin
                        ir_capture = 1'b1;
                        state_d    = ST_EXEC;
                    end else if (tmo_q == TMO_LAST) begin
                        fault_set = 1'b1;
                        state_d   = ST_HALT;
                    end else begin
                        tmo_inc = 1'b1;
                    end
                end
                ST_EXEC: begin
                    am_sel   = ir[A_BIT];
                    alu_ctrl = ir[CTRL_HI:CTRL_LO];
                    if (!ir[IS_C]) begin
                        a_load      = 1'b1;
                        a_sel_instr = 1'b1;
                        pc_inc      = 1'b1;
                        commit      = 1'b1;
                    end else if (ir[DEST_M] && !mem_ready) begin
                        m_write = 1'b1;
                    end else begin
                        m_write = ir[DEST_M];
                        a_load  = ir[DEST_A];
                        d_load  = ir[DEST_D];
                        pc_load = taken;
                        pc_inc  = !taken;
                        commit  = 1'b1;
                    end
                    // A taken jump to itself can never make progress
                    if (commit) begin
                        if (pc_load && (a_val == pc)) begin
                            halt_set = 1'b1;
                            state_d  = ST_HALT;
                        end else begin
                            state_d = run ? ST_FETCH : ST_IDLE;
                        end
                    end
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_RST_PC;
            endcase
        end
    end

    // State, instruction register, counters and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RST_PC;
            ir          <= 16'd0;
            instr_count <= 16'd0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q <= state_d;
            if (ir_capture) begin
                ir    <= instr;
                tmo_q <= '0;
            end else if (tmo_inc) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
            if (fault_set) fault       <= 1'b1;
            if (commit)    instr_count <= instr_count + 16'd1;
            if (halt_set)  halted      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hack_sequencer.sv
// Scoreboard bench for hack_sequencer: directed stimulus pushes the expected strobe
// snapshot for each active cycle; a negedge monitor pops and compares.
module tb_hack_sequencer;

    logic        clk = 1'b0;
    logic        reset, rom_valid, alu_zr, alu_ng, mem_ready, run, step;
    logic [15:0] instr, pc, a_val;
    logic        rom_req, pc_reset, pc_load, pc_inc, a_load, a_sel_instr, d_load, m_write, am_sel;
    logic [5:0]  alu_ctrl;
    logic [15:0] ir, instr_count;
    logic        halted, fault;

    typedef struct packed {
        logic [7:0]  strb;
        logic [6:0]  alu;
        logic [15:0] cnt;
        logic        halted;
        logic        fault;
    } snap_t;

    localparam logic [7:0] S_RST   = 8'b1000_0000;
    localparam logic [7:0] S_REQ   = 8'b0100_0000;
    localparam logic [7:0] S_PCLD  = 8'b0010_0000;
    localparam logic [7:0] S_PCINC = 8'b0001_0000;
    localparam logic [7:0] S_ALD   = 8'b0000_1000;
    localparam logic [7:0] S_ASEL  = 8'b0000_0100;
    localparam logic [7:0] S_DLD   = 8'b0000_0010;
    localparam logic [7:0] S_MW    = 8'b0000_0001;

    snap_t sb_q[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    hack_sequencer #(.FETCH_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .instr(instr), .rom_valid(rom_valid), .rom_req(rom_req),
        .pc(pc), .a_val(a_val), .alu_zr(alu_zr), .alu_ng(alu_ng), .mem_ready(mem_ready),
        .run(run), .step(step), .pc_reset(pc_reset), .pc_load(pc_load), .pc_inc(pc_inc),
        .a_load(a_load), .a_sel_instr(a_sel_instr), .d_load(d_load), .m_write(m_write),
        .am_sel(am_sel), .alu_ctrl(alu_ctrl), .ir(ir), .instr_count(instr_count),
        .halted(halted), .fault(fault)
    );

    // Monitor: any active strobe or request must match the oldest expectation
    always @(negedge clk) begin
        snap_t act;
        snap_t req;
        act = '{strb: {pc_reset, rom_req, pc_load, pc_inc, a_load, a_sel_instr, d_load, m_write},
                alu: {am_sel, alu_ctrl}, cnt: instr_count, halted: halted, fault: fault};
        if (act.strb != 8'h00) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output t=%0t got strb=%b alu=%b cnt=%0d h=%b f=%b required none",
                         $time, act.strb, act.alu, act.cnt, act.halted, act.fault);
            end else begin
                req = sb_q.pop_front();
                if (act !== req) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t got strb=%b alu=%b cnt=%0d h=%b f=%b required strb=%b alu=%b cnt=%0d h=%b f=%b",
                             $time, act.strb, act.alu, act.cnt, act.halted, act.fault,
                             req.strb, req.alu, req.cnt, req.halted, req.fault);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] s, input logic [6:0] a, input int c,
                            input logic h, input logic f);
        snap_t e;
        e = '{strb: s, alu: a, cnt: 16'(c), halted: h, fault: f};
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; run = 1'b0; step = 1'b0; rom_valid = 1'b0; instr = 16'h0000;
        mem_ready = 1'b0; alu_zr = 1'b0; alu_ng = 1'b0; a_val = 16'h0100; pc = 16'h0003;

        // Reset and first A-instruction
        tick();
        push_exp(S_RST, 7'h00, 0, 1'b0, 1'b0); tick();
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_count", 32'(instr_count), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        reset = 1'b0; run = 1'b1;
        push_exp(S_RST, 7'h00, 0, 1'b0, 1'b0); tick();
        tick();
        instr = 16'h0005; rom_valid = 1'b1;
        push_exp(S_REQ, 7'h00, 0, 1'b0, 1'b0); tick();
        rom_valid = 1'b0;
        push_exp(S_PCINC | S_ALD | S_ASEL, 7'h00, 0, 1'b0, 1'b0); tick();
        chk("a_instr_ir", 32'(ir), 32'h0005);
        chk("a_instr_count", 32'(instr_count), 32'd1);

        // M write stalled three cycles on mem_ready
        instr = 16'hE308; rom_valid = 1'b1; mem_ready = 1'b0;
        push_exp(S_REQ, 7'h00, 1, 1'b0, 1'b0); tick();
        rom_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_exp(S_MW, 7'b0001100, 1, 1'b0, 1'b0); tick();
        end
        mem_ready = 1'b1;
        push_exp(S_MW | S_PCINC, 7'b0001100, 1, 1'b0, 1'b0); tick();
        mem_ready = 1'b0;
        chk("mstall_count", 32'(instr_count), 32'd2);

        // JEQ taken on zr, then not taken on ng
        instr = 16'hE302; rom_valid = 1'b1;
        push_exp(S_REQ, 7'h00, 2, 1'b0, 1'b0); tick();
        rom_valid = 1'b0; alu_zr = 1'b1;
        push_exp(S_PCLD, 7'b0001100, 2, 1'b0, 1'b0); tick();
        instr = 16'hE302; rom_valid = 1'b1; alu_zr = 1'b0;
        push_exp(S_REQ, 7'h00, 3, 1'b0, 1'b0); tick();
        rom_valid = 1'b0; alu_ng = 1'b1;
        push_exp(S_PCINC, 7'b0001100, 3, 1'b0, 1'b0); tick();
        alu_ng = 1'b0;

        // AD=A;JGT taken, then D=M with am_sel
        instr = 16'hEC31; rom_valid = 1'b1;
        push_exp(S_REQ, 7'h00, 4, 1'b0, 1'b0); tick();
        rom_valid = 1'b0;
        push_exp(S_PCLD | S_ALD | S_DLD, 7'b0110000, 4, 1'b0, 1'b0); tick();
        instr = 16'hFC10; rom_valid = 1'b1;
        push_exp(S_REQ, 7'h00, 5, 1'b0, 1'b0); tick();
        rom_valid = 1'b0;
        push_exp(S_PCINC | S_DLD, 7'b1110000, 5, 1'b0, 1'b0); tick();
        chk("cinstr_count", 32'(instr_count), 32'd6);

        // 0;JMP to itself -> halt, no further fetch
        instr = 16'hEA87; rom_valid = 1'b1;
        push_exp(S_REQ, 7'h00, 6, 1'b0, 1'b0); tick();
        rom_valid = 1'b0; a_val = 16'h0010; pc = 16'h0010; alu_zr = 1'b1;
        push_exp(S_PCLD, 7'b0101010, 6, 1'b0, 1'b0); tick();
        tick(); tick(); tick();
        chk("halt_halted", 32'(halted), 32'h1);
        chk("halt_fault", 32'(fault), 32'h0);
        chk("halt_count", 32'(instr_count), 32'd7);
        alu_zr = 1'b0; a_val = 16'h0100; pc = 16'h0003;

        // Single step; step held through EXEC is ignored
        reset = 1'b1;
        push_exp(S_RST, 7'h00, 7, 1'b1, 1'b0); tick();
        reset = 1'b0; run = 1'b0;
        push_exp(S_RST, 7'h00, 0, 1'b0, 1'b0); tick();
        tick(); tick();
        step = 1'b1; tick();
        step = 1'b0;
        push_exp(S_REQ, 7'h00, 0, 1'b0, 1'b0); tick();
        instr = 16'h0007; rom_valid = 1'b1;
        push_exp(S_REQ, 7'h00, 0, 1'b0, 1'b0); tick();
        rom_valid = 1'b0; step = 1'b1;
        push_exp(S_PCINC | S_ALD | S_ASEL, 7'h00, 0, 1'b0, 1'b0); tick();
        step = 1'b0;
        tick(); tick(); tick();
        chk("step_count", 32'(instr_count), 32'd1);
        chk("step_ir", 32'(ir), 32'h0007);

        // Fetch timeout after four FETCH cycles
        step = 1'b1; tick();
        step = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_exp(S_REQ, 7'h00, 1, 1'b0, 1'b0); tick();
        end
        tick(); tick(); tick();
        chk("tmo_fault", 32'(fault), 32'h1);
        chk("tmo_halted", 32'(halted), 32'h0);
        chk("tmo_count", 32'(instr_count), 32'd1);

        // Reset in the middle of an M stall
        reset = 1'b1;
        push_exp(S_RST, 7'h00, 1, 1'b0, 1'b1); tick();
        reset = 1'b0; run = 1'b1;
        push_exp(S_RST, 7'h00, 0, 1'b0, 1'b0); tick();
        tick();
        instr = 16'hE308; rom_valid = 1'b1; mem_ready = 1'b0;
        push_exp(S_REQ, 7'h00, 0, 1'b0, 1'b0); tick();
        rom_valid = 1'b0;
        push_exp(S_MW, 7'b0001100, 0, 1'b0, 1'b0); tick();
        reset = 1'b1;
        push_exp(S_RST, 7'h00, 0, 1'b0, 1'b0); tick();
        reset = 1'b0; run = 1'b0;
        push_exp(S_RST, 7'h00, 0, 1'b0, 1'b0); tick();
        tick();
        chk("rst_stall_count", 32'(instr_count), 32'd0);
        chk("rst_stall_fault", 32'(fault), 32'h0);

        tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
